// File: rtl/rv32i_decode.sv
// rv32i_decode: RV32I field extractor, immediate generator and illegal-encoding detector with a sticky flag
module rv32i_decode (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] insn,
   input  logic        insn_valid,
   input  logic        clear_invalid,
   output logic [4:0]  opcode,
   output logic [6:0]  funct7,
   output logic [2:0]  funct3,
   output logic        invalid,
   output logic [4:0]  rd,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [31:0] imm,
   output logic        invalid_seen
);
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic        f7_ok;
   assign opcode = insn[6:2];
   assign funct7 = insn[31:25];
   assign funct3 = insn[14:12];
   assign rd     = insn[11:7];
   assign rs1    = insn[19:15];
   assign rs2    = insn[24:20];
   assign imm_i  = {{20{insn[31]}}, insn[31:20]};
   assign imm_s  = {{20{insn[31]}}, insn[31:25], insn[11:7]};
   assign imm_b  = {{20{insn[31]}}, insn[7], insn[30:25], insn[11:8], 1'b0};
   assign imm_u  = {insn[31:12], 12'h000};
   assign imm_j  = {{12{insn[31]}}, insn[19:12], insn[20], insn[30:21], 1'b0};
   assign f7_ok  = funct7 == 7'b0000000 || funct7 == 7'b0100000;
   always_comb begin
      imm     = '0;
      invalid = 1'b0;
      case (opcode)
         5'b00000: begin imm = imm_i; invalid = funct3 == 3'b011 || funct3[2:1] == 2'b11; end
         5'b00011: imm = imm_i;
         5'b00100: begin
            imm     = imm_i;
            invalid = (funct3 == 3'b001 && funct7 != 7'b0) || (funct3 == 3'b101 && !f7_ok);
         end
         5'b00101: imm = imm_u;
         5'b01000: begin imm = imm_s; invalid = funct3 >= 3'b011; end
         5'b01100: invalid = !f7_ok || (funct7[5] && funct3 != 3'b000 && funct3 != 3'b101);
         5'b01101: imm = imm_u;
         5'b11000: begin imm = imm_b; invalid = funct3[2:1] == 2'b01; end
         5'b11001: begin imm = imm_i; invalid = funct3 != 3'b000; end
         5'b11011: imm = imm_j;
         5'b11100: begin imm = imm_i; invalid = funct3 == 3'b100; end
         default:  invalid = 1'b1;
      endcase
      if (insn[1:0] != 2'b11) invalid = 1'b1;
   end
   // clear beats a same-cycle illegal instruction
   always_ff @(posedge clk)
      invalid_seen <= !rst ? 1'b0 : clear_invalid ? 1'b0 : (insn_valid && invalid) ? 1'b1 : invalid_seen;
endmodule

// File: tb/tb_rv32i_decode.sv
// tb_rv32i_decode: directed and randomized checks of rv32i_decode against a table-driven reference model
module tb_rv32i_decode;
   logic        clk = 1'b0;
   logic        rst, insn_valid, clear_invalid;
   logic [31:0] insn;
   logic [4:0]  opcode, rd, rs1, rs2;
   logic [6:0]  funct7;
   logic [2:0]  funct3;
   logic        invalid, invalid_seen;
   logic [31:0] imm;
   int          n_pass = 0, n_total = 0;
   logic        seen;
   logic [4:0]  ops [11] = '{5'h00, 5'h03, 5'h04, 5'h05, 5'h08, 5'h0C, 5'h0D, 5'h18, 5'h19, 5'h1B, 5'h1C};

   rv32i_decode dut (
      .clk(clk), .rst(rst), .insn(insn), .insn_valid(insn_valid), .clear_invalid(clear_invalid),
      .opcode(opcode), .funct7(funct7), .funct3(funct3), .invalid(invalid),
      .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .invalid_seen(invalid_seen)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h insn=%h", tag, got, exp, insn);
   endtask

   // format letter and allowed-funct3 mask per opcode, then the funct7 side rules
   function automatic void model(input logic [31:0] w, output logic [31:0] e_imm, output logic e_inv);
      byte        fmt;
      logic [7:0] f3_ok;
      logic       known;
      int         f3, f7;
      f3 = int'(w[14:12]);
      f7 = int'(w[31:25]);
      known = 1'b1;
      f3_ok = 8'hFF;
      case (w[6:2])
         5'h00: begin fmt = "I"; f3_ok = 8'b0011_0111; end
         5'h03: fmt = "I";
         5'h04: fmt = "I";
         5'h05: fmt = "U";
         5'h08: begin fmt = "S"; f3_ok = 8'b0000_0111; end
         5'h0C: fmt = "N";
         5'h0D: fmt = "U";
         5'h18: begin fmt = "B"; f3_ok = 8'b1111_0011; end
         5'h19: begin fmt = "I"; f3_ok = 8'b0000_0001; end
         5'h1B: fmt = "J";
         5'h1C: begin fmt = "I"; f3_ok = 8'b1110_1111; end
         default: begin fmt = "N"; known = 1'b0; end
      endcase
      e_inv = w[1:0] != 2'b11 || !known || !f3_ok[f3];
      if (w[6:2] == 5'h0C)
         e_inv = e_inv || !(f7 == 0 || f7 == 32) || (f7 == 32 && !(f3 == 0 || f3 == 5));
      if (w[6:2] == 5'h04)
         e_inv = e_inv || (f3 == 1 && f7 != 0) || (f3 == 5 && !(f7 == 0 || f7 == 32));
      case (fmt)
         "I": e_imm = 32'($signed(w) >>> 20);
         "S": e_imm = 32'(($signed(w) >>> 25) <<< 5) | 32'(w[11:7]);
         "B": e_imm = 32'(($signed(w) >>> 31) <<< 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
         "U": e_imm = w & 32'hFFFF_F000;
         "J": e_imm = 32'(($signed(w) >>> 31) <<< 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
         default: e_imm = 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] rand_insn();
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(0, 9) != 0) begin
         w[1:0] = 2'b11;
         if ($urandom_range(0, 7) != 0) w[6:2] = ops[$urandom_range(0, 10)];
         case ($urandom_range(0, 2))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            default: ;
         endcase
      end
      return w;
   endfunction

   task automatic check_comb(input string tag);
      logic [31:0] e_imm;
      logic        e_inv;
      model(insn, e_imm, e_inv);
      check({tag, ".imm"}, imm, e_imm);
      check({tag, ".invalid"}, 32'(invalid), 32'(e_inv));
      check({tag, ".fields"}, {2'b0, opcode, funct7, funct3, rd, rs1, rs2},
            {2'b0, insn[6:2], insn[31:25], insn[14:12], insn[11:7], insn[19:15], insn[24:20]});
   endtask

   task automatic step(input string tag);
      logic [31:0] e_imm;
      logic        e_inv;
      model(insn, e_imm, e_inv);
      seen = !rst ? 1'b0 : clear_invalid ? 1'b0 : (insn_valid && e_inv) ? 1'b1 : seen;
      @(posedge clk);
      #1;
      check(tag, 32'(invalid_seen), 32'(seen));
   endtask

   task automatic vec(input logic [31:0] w, input logic [31:0] e_imm, input logic e_inv);
      insn = w;
      #1;
      check("dir.imm", imm, e_imm);
      check("dir.invalid", 32'(invalid), 32'(e_inv));
   endtask

   initial begin
      rst = 1'b0; insn_valid = 1'b0; clear_invalid = 1'b0; insn = 32'h0000_0013;
      seen = 1'b0;
      @(negedge clk);
      step("reset");
      rst = 1'b1;
      insn = 32'h0050_0093;
      #1;
      check("addi.fields", {opcode, rd, rs1, funct3}, {5'b00100, 5'd1, 5'd0, 3'd0});
      vec(32'h0050_0093, 32'd5, 1'b0);
      vec(32'hFE00_0EE3, 32'hFFFF_FFFC, 1'b0);
      check("beq.opcode", 32'(opcode), 32'h18);
      vec(32'h0011_2623, 32'd12, 1'b0);
      check("sw.regs", {rs1, rs2}, {5'd2, 5'd1});
      vec(32'h1234_50B7, 32'h1234_5000, 1'b0);
      check("lui.rd", 32'(rd), 32'd1);
      vec(32'h0040_006F, 32'd4, 1'b0);
      vec(32'h8000_00EF, 32'hFFF0_0000, 1'b0);
      vec(32'h40B5_0533, 32'h0, 1'b0);
      vec(32'h0000_0000, 32'h0, 1'b1);
      vec(32'hFFFF_FFFF, 32'h0, 1'b1);
      vec(32'h0000_A003, 32'h0, 1'b0);
      vec(32'h0000_3003, 32'h0, 1'b1);
      @(negedge clk);
      insn = 32'h0000_0000; insn_valid = 1'b0;
      step("seen.unqualified");
      insn_valid = 1'b1;
      step("seen.set");
      insn = 32'h0050_0093;
      step("seen.hold");
      insn = 32'hFFFF_FFFF; clear_invalid = 1'b1;
      step("seen.clear_wins");
      clear_invalid = 1'b0;
      step("seen.set2");
      rst = 1'b0;
      #1;
      check("rst.comb_invalid", 32'(invalid), 32'h1);
      step("seen.reset_mid");
      for (int i = 0; i < 400; i++) begin
         rst           = $urandom_range(0, 15) != 0;
         insn_valid    = $urandom_range(0, 1) == 1;
         clear_invalid = $urandom_range(0, 9) == 0;
         insn          = rand_insn();
         #1;
         check_comb("rnd");
         step("rnd.seen");
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
